// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial adder.
package serial_add_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} sa_state_t;

    localparam int SA_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_add_unit_fa_cell.sv
// Combinational one-bit full adder used as the serial datapath slice.
module fa_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/serial_add_unit.sv
// Bit-serial two's-complement adder: one sum bit per clock, LSB first,
// behind a start/busy/done handshake.
module serial_add_unit
    import serial_add_pkg::*;
#(
    parameter int WIDTH = SA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    sa_state_t        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             load;
    logic             bit_s, bit_co;

    fa_cell u_fa (
        .x  (a_sh_q[0]),
        .y  (b_sh_q[0]),
        .ci (carry_q),
        .s  (bit_s),
        .co (bit_co)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        load    = (state_q != SHIFT) && start;

        case (state_q)
            IDLE:  if (start) state_d = SHIFT;
            SHIFT: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                res_d   = {bit_s, res_q[WIDTH-1:1]};
                carry_d = bit_co;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    sum_d   = {bit_s, res_q[WIDTH-1:1]};
                    cout_d  = bit_co;
                    // carry_q here is the carry into the MSB
                    ovf_d   = carry_q ^ bit_co;
                end
            end
            DONE:    state_d = start ? SHIFT : IDLE;
            default: state_d = IDLE;
        endcase

        if (load) begin
            a_sh_d  = a;
            b_sh_d  = b;
            carry_d = cin;
            cnt_d   = '0;
            res_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ready = (state_q != SHIFT);
    assign busy  = (state_q == SHIFT);
    assign done  = (state_q == DONE);
    assign sum   = sum_q;
    assign cout  = cout_q;
    assign ovf   = ovf_q;

endmodule
